// File: rtl/v_mem_seq.sv
// Multi-beat vector-memory command sequencer: drives the VMEM port for N beats per command,
// feeding back a running accumulator on load/MAC beats and streaming store data on store beats.
module v_mem_seq #(
    parameter int unsigned VMEM_AW = 64,
    parameter int unsigned VMEM_DW = 512,
    parameter int unsigned ACC_W   = 1024,
    parameter int unsigned BEAT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_store_i,
    input  logic [4:0]         cmd_opcode_i,
    input  logic [VMEM_AW-1:0] cmd_base_i,
    input  logic [15:0]        cmd_stride_i,
    input  logic [BEAT_W-1:0]  cmd_beats_i,
    input  logic               cmd_clr_i,
    input  logic               coef_valid_i,
    output logic               coef_ready_o,
    input  logic [31:0]        coef_data_i,
    input  logic               wdat_valid_i,
    output logic               wdat_ready_o,
    input  logic [VMEM_DW-1:0] wdat_data_i,
    output logic               vmem_ren_o,
    output logic               vmem_wen_o,
    output logic [VMEM_AW-1:0] vmem_addr_o,
    output logic [VMEM_DW-1:0] vmem_din_o,
    output logic [4:0]         vmem_opcode_o,
    output logic [31:0]        vmem_vs2select_o,
    output logic [ACC_W-1:0]   vd_data_o,
    input  logic [ACC_W-1:0]   vmem_dout_i,
    output logic [ACC_W-1:0]   acc_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [VMEM_AW-1:0]  addr;
    logic [15:0]         stride;
    logic [BEAT_W-1:0]   count;
    logic [4:0]          opcode;
    logic [ACC_W-1:0]    acc;
    logic                accept;
    logic                beat;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode; beats are suppressed while reset is asserted
    always_comb begin
        state_nxt    = state;
        cmd_ready_o  = 1'b0;
        coef_ready_o = 1'b0;
        wdat_ready_o = 1'b0;
        vmem_ren_o   = 1'b0;
        vmem_wen_o   = 1'b0;
        accept       = 1'b0;
        beat         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = rst;
                accept      = rst & cmd_valid_i;
                if (accept) begin
                    if (cmd_beats_i == '0) begin
                        state_nxt = DONE;
                    end else if (cmd_store_i) begin
                        state_nxt = STORE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                coef_ready_o = rst;
                vmem_ren_o   = rst & coef_valid_i;
                beat         = rst & coef_valid_i;
                if (beat && count == BEAT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            STORE: begin
                wdat_ready_o = rst;
                vmem_wen_o   = rst & wdat_valid_i;
                beat         = rst & wdat_valid_i;
                if (beat && count == BEAT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, per-beat address/count stepping and accumulator capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc    <= '0;
            addr   <= '0;
            stride <= '0;
            count  <= '0;
            opcode <= '0;
        end else if (accept) begin
            addr   <= cmd_base_i;
            stride <= cmd_stride_i;
            count  <= cmd_beats_i;
            opcode <= cmd_opcode_i;
            if (cmd_clr_i) begin
                acc <= '0;
            end
        end else if (beat) begin
            addr  <= addr + VMEM_AW'(stride);
            count <= count - BEAT_W'(1);
            if (state == LOAD) begin
                acc <= vmem_dout_i;
            end
        end
    end

    assign vmem_addr_o      = addr;
    assign vmem_opcode_o    = opcode;
    assign vmem_din_o       = wdat_data_i;
    assign vmem_vs2select_o = coef_data_i;
    assign vd_data_o        = acc;
    assign acc_o            = acc;
    assign busy_o           = (state != IDLE);
    assign done_o           = (state == DONE);

endmodule
